// File: rtl/seq_mult_param.sv
// Parametrised sequential shift-add multiplier: one partial product per clock,
// runtime signed/unsigned mode, start/busy/done handshake, product held until next accept.
module seq_mult_param #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t state, state_next;

    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] addend;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH-1:0]   mreg;
    logic [CNT_W-1:0]   count;
    logic               mode_q;
    logic               accept;
    logic               last_step;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (last_step) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = start ? CALC : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // The multiplier's top bit carries weight -2^(W-1) in signed mode, so the last step subtracts.
    always_comb begin
        accept    = start && ((state == IDLE) || (state == DONE));
        last_step = (count == CNT_W'(WIDTH - 1));
        addend    = mreg[0] ? mcand : '0;
        acc_next  = (last_step && mode_q) ? (acc - addend) : (acc + addend);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            acc     <= '0;
            mcand   <= '0;
            mreg    <= '0;
            count   <= '0;
            mode_q  <= 1'b0;
            product <= '0;
        end else if (accept) begin
            acc    <= '0;
            count  <= '0;
            mreg   <= b;
            mcand  <= signed_mode ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
            mode_q <= signed_mode;
        end else if (state == CALC) begin
            acc   <= acc_next;
            count <= count + CNT_W'(1);
            mcand <= mcand << 1;
            mreg  <= mreg >> 1;
            if (last_step) begin
                product <= acc_next;
            end
        end
    end

endmodule
